pong_match_ctrl: RTL and testbench

Match sequencer for the pong game. It runs the game through idle, serve, rally, point-pause and game-over phases. It counts frames from the VGA pixel scan and keeps the two 2-bit player scores. It drives the ball/paddle control signals (`start`, `guiwei`) and the `score` bus consumed by the paddle, ball and display blocks, replacing the raw start switch as the owner of those signals.

---
 rtl/pong_match_ctrl_pkg.sv | 25 ++
 rtl/pong_match_ctrl_frame_timer.sv | 41 ++++
 rtl/pong_match_ctrl.sv | 142 ++++++++++++++
 tb/tb_pong_match_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_match_ctrl_pkg.sv
// Shared definitions for the pong match sequencer: phase encodings,
// default scan geometry and winner codes.
package pong_match_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } match_state_t;

  localparam int DEF_H_DISP = 640;
  localparam int DEF_V_DISP = 480;

  localparam logic [1:0] WINNER_NONE  = 2'b00;
  localparam logic [1:0] WINNER_LEFT  = 2'b10;
  localparam logic [1:0] WINNER_RIGHT = 2'b01;

  // A 2-bit score sticks at 3 instead of wrapping to 0.
  function automatic logic [1:0] sat_inc(input logic [1:0] s);
    return (s == 2'd3) ? s : s + 2'd1;
  endfunction

endpackage

// File: rtl/pong_match_ctrl_frame_timer.sv
// Frame tick from the last visible pixel of the scan, plus a loadable
// down-counter of frame ticks that flags done on its final tick.
module pong_match_ctrl_frame_timer
  import pong_match_ctrl_pkg::*;
#(
  parameter int H_DISP = DEF_H_DISP,
  parameter int V_DISP = DEF_V_DISP,
  parameter int CNT_W  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       pixel_xpos,
  input  logic [9:0]       pixel_ypos,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tick,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= 1'b0;
      cnt  <= '0;
    end else begin
      tick <= (pixel_xpos == 10'(H_DISP - 1)) && (pixel_ypos == 10'(V_DISP - 1));
      if (load)
        cnt <= load_val;
      else if (en && tick && (cnt != '0))
        cnt <= cnt - CNT_W'(1);
    end
  end

  // Loaded with N-1, so the Nth counted tick is the one that sees zero.
  assign done = en && tick && (cnt == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: idle/serve/play/point/over phases, 2-bit scores per
// player, and registered paddle/ball control outputs.
module pong_match_ctrl
  import pong_match_ctrl_pkg::*;
#(
  parameter int H_DISP       = DEF_H_DISP,
  parameter int V_DISP       = DEF_V_DISP,
  parameter int WIN_SCORE    = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  input  logic       start_sw,
  input  logic [9:0] pixel_xpos,
  input  logic [9:0] pixel_ypos,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       start,
  output logic       guiwei,
  output logic [3:0] score,
  output logic [1:0] winner,
  output logic       serve_dir,
  output logic       frame_tick
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LOAD = CNT_W'(POINT_FRAMES - 1);
  localparam logic [1:0]       WIN        = 2'(WIN_SCORE);

  match_state_t     state;
  logic [1:0]       left_score;
  logic [1:0]       right_score;
  logic             sw_q;
  logic             armed;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_en;
  logic             timer_done;

  assign score    = {left_score, right_score};
  assign timer_en = (state == SERVE) || (state == POINT);

  // The counter is reloaded while in the phase that precedes the one it
  // times, so it is already fresh on the entry edge.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = SERVE_LOAD;
    case (state)
      IDLE:    timer_load = 1'b1;
      PLAY:    begin timer_load = 1'b1; timer_val = POINT_LOAD; end
      POINT:   timer_load = timer_done;
      default: ;
    endcase
  end

  pong_match_ctrl_frame_timer #(
    .H_DISP (H_DISP),
    .V_DISP (V_DISP),
    .CNT_W  (CNT_W)
  ) u_frame_timer (
    .clk        (vga_clk),
    .rst        (sys_rst),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .load       (timer_load),
    .load_val   (timer_val),
    .en         (timer_en),
    .tick       (frame_tick),
    .done       (timer_done)
  );

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      left_score  <= 2'd0;
      right_score <= 2'd0;
      winner      <= WINNER_NONE;
      serve_dir   <= 1'b0;
      start       <= 1'b0;
      guiwei      <= 1'b1;
      sw_q        <= 1'b0;
      armed       <= 1'b0;
    end else begin
      sw_q   <= start_sw;
      start  <= (state == PLAY);
      guiwei <= (state != PLAY);
      // A switch already high out of reset must be cycled before a match starts.
      if (!start_sw)
        armed <= 1'b1;

      if (!start_sw && (state != IDLE)) begin
        state       <= IDLE;
        left_score  <= 2'd0;
        right_score <= 2'd0;
        winner      <= WINNER_NONE;
      end else begin
        case (state)
          IDLE: begin
            left_score  <= 2'd0;
            right_score <= 2'd0;
            winner      <= WINNER_NONE;
            if (start_sw && !sw_q && armed)
              state <= SERVE;
          end
          SERVE: if (timer_done) state <= PLAY;
          PLAY: begin
            if (miss_left && miss_right) begin
              state <= POINT;
            end else if (miss_left) begin
              right_score <= sat_inc(right_score);
              serve_dir   <= 1'b0;
              if (sat_inc(right_score) == WIN) begin
                state  <= OVER;
                winner <= WINNER_RIGHT;
              end else begin
                state <= POINT;
              end
            end else if (miss_right) begin
              left_score <= sat_inc(left_score);
              serve_dir  <= 1'b1;
              if (sat_inc(left_score) == WIN) begin
                state  <= OVER;
                winner <= WINNER_LEFT;
              end else begin
                state <= POINT;
              end
            end
          end
          POINT:   if (timer_done) state <= SERVE;
          OVER:    ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with a tiny scan (8x4) and an
// independent per-cycle model of the match rules.
module tb_pong_match_ctrl;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int SF = 2;
  localparam int PF = 3;
  localparam int WS = 3;

  localparam int P_IDLE  = 0;
  localparam int P_SERVE = 1;
  localparam int P_PLAY  = 2;
  localparam int P_POINT = 3;
  localparam int P_OVER  = 4;

  logic       clk = 1'b0;
  logic       sys_rst, start_sw, miss_left, miss_right;
  logic [9:0] pixel_xpos, pixel_ypos;
  logic       start, guiwei, serve_dir, frame_tick;
  logic [3:0] score;
  logic [1:0] winner;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pong_match_ctrl #(
    .H_DISP       (H),
    .V_DISP       (V),
    .WIN_SCORE    (WS),
    .SERVE_FRAMES (SF),
    .POINT_FRAMES (PF)
  ) dut (
    .vga_clk    (clk),
    .sys_rst    (sys_rst),
    .start_sw   (start_sw),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .miss_left  (miss_left),
    .miss_right (miss_right),
    .start      (start),
    .guiwei     (guiwei),
    .score      (score),
    .winner     (winner),
    .serve_dir  (serve_dir),
    .frame_tick (frame_tick)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Free-running raster scan
  initial begin
    pixel_xpos = 10'd0;
    pixel_ypos = 10'd0;
    forever begin
      @(negedge clk);
      if (pixel_xpos == 10'(H - 1)) begin
        pixel_xpos = 10'd0;
        pixel_ypos = (pixel_ypos == 10'(V - 1)) ? 10'd0 : pixel_ypos + 10'd1;
      end else begin
        pixel_xpos = pixel_xpos + 10'd1;
      end
    end
  end

  // Behavioural model of the match rules, advanced once per clock edge.
  int m_phase, m_ticks, m_left, m_right, m_win, nxt;
  bit m_dir, m_start, m_guiwei, m_tick, m_prev_sw, m_seen_low;
  bit c_rst, c_sw, c_ml, c_mr, c_end;

  function automatic logic [1:0] winner_code(input int w);
    return (w == 1) ? 2'b10 : (w == 2) ? 2'b01 : 2'b00;
  endfunction

  always begin
    @(posedge clk);
    c_rst = sys_rst;
    c_sw  = start_sw;
    c_ml  = miss_left;
    c_mr  = miss_right;
    c_end = (pixel_xpos == 10'(H - 1)) && (pixel_ypos == 10'(V - 1));
    #1;
    if (c_rst) begin
      m_phase = P_IDLE; m_ticks = 0; m_left = 0; m_right = 0; m_win = 0;
      m_dir = 0; m_start = 0; m_guiwei = 1; m_tick = 0; m_prev_sw = 0; m_seen_low = 0;
    end else begin
      m_start  = (m_phase == P_PLAY);
      m_guiwei = !m_start;
      nxt = m_phase;
      if (!c_sw && m_phase != P_IDLE) begin
        nxt = P_IDLE; m_left = 0; m_right = 0; m_win = 0;
      end else begin
        case (m_phase)
          P_IDLE: begin
            m_left = 0; m_right = 0; m_win = 0;
            if (c_sw && !m_prev_sw && m_seen_low) begin nxt = P_SERVE; m_ticks = 0; end
          end
          P_SERVE: if (m_tick) begin
            m_ticks++;
            if (m_ticks == SF) nxt = P_PLAY;
          end
          P_PLAY: begin
            if (c_ml && c_mr) begin
              nxt = P_POINT; m_ticks = 0;
            end else if (c_ml) begin
              m_right = (m_right + 1 > 3) ? 3 : m_right + 1;
              m_dir = 0;
              if (m_right == WS) begin nxt = P_OVER; m_win = 2; end
              else begin nxt = P_POINT; m_ticks = 0; end
            end else if (c_mr) begin
              m_left = (m_left + 1 > 3) ? 3 : m_left + 1;
              m_dir = 1;
              if (m_left == WS) begin nxt = P_OVER; m_win = 1; end
              else begin nxt = P_POINT; m_ticks = 0; end
            end
          end
          P_POINT: if (m_tick) begin
            m_ticks++;
            if (m_ticks == PF) begin nxt = P_SERVE; m_ticks = 0; end
          end
          default: ;
        endcase
      end
      m_phase   = nxt;
      m_prev_sw = c_sw;
      if (!c_sw) m_seen_low = 1;
      m_tick = c_end;
    end
    check("m_start",      8'(start),      8'(m_start));
    check("m_guiwei",     8'(guiwei),     8'(m_guiwei));
    check("m_score",      8'(score),      8'({m_left[1:0], m_right[1:0]}));
    check("m_winner",     8'(winner),     8'(winner_code(m_win)));
    check("m_serve_dir",  8'(serve_dir),  8'(m_dir));
    check("m_frame_tick", 8'(frame_tick), 8'(m_tick));
  end

  task automatic pulse(input logic l, input logic r);
    miss_left  = l;
    miss_right = r;
    @(negedge clk);
    miss_left  = 1'b0;
    miss_right = 1'b0;
  endtask

  task automatic wait_start(input logic val);
    int n = 0;
    while (start !== val && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wait_start", 8'(start), 8'(val));
  endtask

  task automatic next_rally();
    wait_start(1'b0);
    wait_start(1'b1);
  endtask

  initial begin
    sys_rst    = 1'b1;
    start_sw   = 1'b1;
    miss_left  = 1'b0;
    miss_right = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_score", 8'(score), 8'h00);
    check("rst_guiwei", 8'(guiwei), 8'h01);
    check("rst_start", 8'(start), 8'h00);
    sys_rst = 1'b0;

    // Switch held high out of reset: must stay idle
    repeat (40) @(negedge clk);
    check("idle_hold_start", 8'(start), 8'h00);
    check("idle_hold_guiwei", 8'(guiwei), 8'h01);

    start_sw = 1'b0;
    repeat (2) @(negedge clk);
    start_sw = 1'b1;
    repeat (3) @(negedge clk);
    pulse(1'b1, 1'b0);                      // in SERVE: ignored
    check("serve_miss_score", 8'(score), 8'h00);

    wait_start(1'b1);
    check("play_guiwei", 8'(guiwei), 8'h00);
    pulse(1'b0, 1'b1);
    check("miss_r_score", 8'(score), 8'b0100);
    check("miss_r_dir", 8'(serve_dir), 8'h01);
    pulse(1'b1, 1'b0);                      // in POINT: ignored
    check("point_miss_score", 8'(score), 8'b0100);

    next_rally();
    pulse(1'b0, 1'b1);
    check("left2_score", 8'(score), 8'b1000);

    next_rally();
    pulse(1'b1, 1'b1);
    check("both_score", 8'(score), 8'b1000);
    check("both_dir", 8'(serve_dir), 8'h01);

    next_rally();
    pulse(1'b0, 1'b1);
    check("win_score", 8'(score), 8'b1100);
    check("win_winner", 8'(winner), 8'b10);
    pulse(1'b1, 1'b0);                      // in OVER: ignored
    repeat (70) @(negedge clk);
    check("over_score", 8'(score), 8'b1100);
    check("over_winner", 8'(winner), 8'b10);
    check("over_start", 8'(start), 8'h00);

    start_sw = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_over_score", 8'(score), 8'h00);
    check("abort_over_winner", 8'(winner), 8'h00);

    start_sw = 1'b1;
    wait_start(1'b1);
    pulse(1'b0, 1'b1);
    next_rally();
    pulse(1'b1, 1'b0);
    next_rally();
    pulse(1'b1, 1'b0);
    check("mid_score", 8'(score), 8'b0110);
    check("mid_dir", 8'(serve_dir), 8'h00);
    next_rally();

    // Abort mid-play with a simultaneous miss
    start_sw  = 1'b0;
    miss_left = 1'b1;
    @(negedge clk);
    miss_left = 1'b0;
    check("abort_play_score", 8'(score), 8'h00);
    @(negedge clk);
    check("abort_play_start", 8'(start), 8'h00);
    check("abort_play_guiwei", 8'(guiwei), 8'h01);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
